mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_if.sv | 47 ++++
 rtl/mc_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, strobes/selects/status out.
// Purely wiring; no latency of its own.
// No backpressure beyond mem_ready, which the controller samples only in FETCH and MEM.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  // datapath -> controller
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  // controller -> datapath strobes
  logic             pc_we;
  logic             ir_we;
  logic             reg_we;
  logic             mem_re;
  logic             mem_we;
  // controller -> datapath selects
  logic             iord;
  logic             alu_src_a;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             ext_op;
  logic [1:0]       alu_src_b;
  logic [1:0]       pc_src;
  logic [5:0]       aluop;
  // status
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  // controller side
  modport master (
    input  op, funct, zero, mem_ready,
    output pc_we, ir_we, reg_we, mem_re, mem_we,
    output iord, alu_src_a, reg_dst, mem_to_reg, ext_op, alu_src_b, pc_src, aluop,
    output state, illegal, instr_cnt
  );

  // datapath side
  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_we, ir_we, reg_we, mem_re, mem_we,
    input  iord, alu_src_a, reg_dst, mem_to_reg, ext_op, alu_src_b, pc_src, aluop,
    input  state, illegal, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB); outputs are combinational from state and inputs.
// Latency: j 2, beq 3, ALU ops 4, sw 4, lw 5 cycles; each mem_ready=0 cycle in FETCH/MEM adds one.
// Backpressure: mem_ready low holds FETCH/MEM with the memory strobe asserted. Optional MC_CTRL_PERF_CNT_EN adds a retired-instruction counter.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.master  ctrl_bus
);

  localparam logic [5:0] ALU_ADDU = 6'h21;
  localparam logic [5:0] ALU_SUBU = 6'h23;
  localparam logic [5:0] ALU_ADD  = 6'h20;
  localparam logic [5:0] ALU_AND  = 6'h24;
  localparam logic [5:0] ALU_OR   = 6'h25;
  localparam logic [5:0] ALU_SLT  = 6'h2A;
  localparam logic [5:0] ALU_LUI  = 6'h0F;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_done;
  logic       w_is_r;
  logic       w_is_addiu;
  logic       w_is_ori;
  logic       w_is_lui;
  logic       w_is_lw;
  logic       w_is_sw;
  logic       w_is_beq;
  logic       w_is_j;
  logic       w_legal;
  logic [5:0] w_r_aluop;

  // Instruction decode from the IR fields; R-type legality depends on funct.
  always_comb begin
    w_is_r    = 1'b0;
    w_r_aluop = ALU_ADDU;
    if (ctrl_bus.op == 6'h00) begin
      w_is_r = 1'b1;
      case (ctrl_bus.funct)
        6'h21:   w_r_aluop = ALU_ADDU;
        6'h23:   w_r_aluop = ALU_SUBU;
        6'h20:   w_r_aluop = ALU_ADD;
        6'h24:   w_r_aluop = ALU_AND;
        6'h25:   w_r_aluop = ALU_OR;
        6'h2A:   w_r_aluop = ALU_SLT;
        default: w_is_r    = 1'b0;
      endcase
    end
    w_is_addiu = (ctrl_bus.op == 6'h09);
    w_is_ori   = (ctrl_bus.op == 6'h0D);
    w_is_lui   = (ctrl_bus.op == 6'h0F);
    w_is_lw    = (ctrl_bus.op == 6'h23);
    w_is_sw    = (ctrl_bus.op == 6'h2B);
    w_is_beq   = (ctrl_bus.op == 6'h04);
    w_is_j     = (ctrl_bus.op == 6'h02);
    w_legal    = w_is_r | w_is_addiu | w_is_ori | w_is_lui | w_is_lw |
                 w_is_sw | w_is_beq | w_is_j;
  end

  // Per-state strobes/selects and next state; reset forces every output quiet.
  always_comb begin
    ctrl_bus.pc_we      = 1'b0;
    ctrl_bus.ir_we      = 1'b0;
    ctrl_bus.reg_we     = 1'b0;
    ctrl_bus.mem_re     = 1'b0;
    ctrl_bus.mem_we     = 1'b0;
    ctrl_bus.iord       = 1'b0;
    ctrl_bus.alu_src_a  = 1'b0;
    ctrl_bus.reg_dst    = 1'b0;
    ctrl_bus.mem_to_reg = 1'b0;
    ctrl_bus.ext_op     = 1'b0;
    ctrl_bus.alu_src_b  = 2'b00;
    ctrl_bus.pc_src     = 2'b00;
    ctrl_bus.aluop      = ALU_ADDU;
    ctrl_bus.illegal    = 1'b0;
    w_next              = r_state;
    w_done              = 1'b0;
    case (r_state)
      S_FETCH: begin
        ctrl_bus.mem_re = 1'b1;
        if (ctrl_bus.mem_ready) begin
          ctrl_bus.ir_we     = 1'b1;
          ctrl_bus.pc_we     = 1'b1;
          ctrl_bus.alu_src_b = 2'b01;
          w_next             = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is examined
        ctrl_bus.alu_src_b = 2'b11;
        if (!w_legal) begin
          ctrl_bus.illegal = 1'b1;
          w_next           = S_FETCH;
        end else if (w_is_j) begin
          ctrl_bus.pc_we  = 1'b1;
          ctrl_bus.pc_src = 2'b10;
          w_next          = S_FETCH;
          w_done          = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_r) begin
          ctrl_bus.alu_src_a = 1'b1;
          ctrl_bus.aluop     = w_r_aluop;
          w_next             = S_WB;
        end else if (w_is_addiu | w_is_ori | w_is_lui) begin
          ctrl_bus.alu_src_a = 1'b1;
          ctrl_bus.alu_src_b = 2'b10;
          ctrl_bus.ext_op    = w_is_addiu;
          ctrl_bus.aluop     = w_is_ori ? ALU_OR : (w_is_lui ? ALU_LUI : ALU_ADDU);
          w_next             = S_WB;
        end else if (w_is_lw | w_is_sw) begin
          // effective address = rs + sign-extended offset
          ctrl_bus.alu_src_a = 1'b1;
          ctrl_bus.alu_src_b = 2'b10;
          ctrl_bus.ext_op    = 1'b1;
          w_next             = S_MEM;
        end else if (w_is_beq) begin
          ctrl_bus.alu_src_a = 1'b1;
          ctrl_bus.aluop     = ALU_SUBU;
          ctrl_bus.pc_src    = 2'b01;
          ctrl_bus.pc_we     = ctrl_bus.zero;
          w_next             = S_FETCH;
          w_done             = 1'b1;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEM: begin
        ctrl_bus.iord = 1'b1;
        if (w_is_lw) begin
          ctrl_bus.mem_re = 1'b1;
          if (ctrl_bus.mem_ready) w_next = S_WB;
        end else if (w_is_sw) begin
          ctrl_bus.mem_we = 1'b1;
          if (ctrl_bus.mem_ready) begin
            w_next = S_FETCH;
            w_done = 1'b1;
          end
        end else begin
          w_next = S_FETCH;
        end
      end
      S_WB: begin
        ctrl_bus.reg_we     = 1'b1;
        ctrl_bus.reg_dst    = w_is_r;
        ctrl_bus.mem_to_reg = w_is_lw;
        w_next              = S_FETCH;
        w_done              = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    if (!rst) begin
      ctrl_bus.pc_we      = 1'b0;
      ctrl_bus.ir_we      = 1'b0;
      ctrl_bus.reg_we     = 1'b0;
      ctrl_bus.mem_re     = 1'b0;
      ctrl_bus.mem_we     = 1'b0;
      ctrl_bus.iord       = 1'b0;
      ctrl_bus.alu_src_a  = 1'b0;
      ctrl_bus.reg_dst    = 1'b0;
      ctrl_bus.mem_to_reg = 1'b0;
      ctrl_bus.ext_op     = 1'b0;
      ctrl_bus.alu_src_b  = 2'b00;
      ctrl_bus.pc_src     = 2'b00;
      ctrl_bus.aluop      = ALU_ADDU;
      ctrl_bus.illegal    = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  assign ctrl_bus.state = r_state;

`ifdef MC_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_instr_cnt;

  // Retired-instruction counter: bumps on each legal completion returning to FETCH, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst)                              r_instr_cnt <= '0;
    else if (w_done && w_next == S_FETCH)  r_instr_cnt <= r_instr_cnt + 1'b1;
  end

  assign ctrl_bus.instr_cnt = r_instr_cnt;
`else
  logic w_done_unused;
  assign w_done_unused      = w_done;
  assign ctrl_bus.instr_cnt = '0;
`endif

endmodule
